// File: rtl/e_mdu_ctrl.sv
// e_mdu_ctrl: E-stage multiply/divide controller that owns the HI/LO registers.
// A down-counter models the fixed mult/div latency and drives the D-stage MD stall.
`timescale 1ns/1ps
module e_mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] E_instruction,
   input  logic [31:0] E_rs_data,
   input  logic [31:0] E_rt_data,
   input  logic        D_is_md,
   output logic        E_mdu_start,
   output logic        E_mdu_busy,
   output logic        E_mdu_stall,
   output logic        E_is_mf,
   output logic [31:0] E_mdu_out,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MTHI  = 6'b010001;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MTLO  = 6'b010011;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;

   localparam logic [1:0] OP_MULT  = 2'd0;
   localparam logic [1:0] OP_MULTU = 2'd1;
   localparam logic [1:0] OP_DIV   = 2'd2;
   localparam logic [1:0] OP_DIVU  = 2'd3;

   logic [CW-1:0] r_cnt;
   logic [1:0]    r_op;
   logic [31:0]   r_opA;
   logic [31:0]   r_opB;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;

   logic [5:0]    w_opcode;
   logic [5:0]    w_funct;
   logic          w_isSpecial;
   logic          w_isMult;
   logic          w_isMultu;
   logic          w_isDiv;
   logic          w_isDivu;
   logic          w_isMfhi;
   logic          w_isMflo;
   logic          w_isMthi;
   logic          w_isMtlo;
   logic          w_unusedFields;

   logic          w_start;
   logic          w_busy;
   logic          w_commit;
   logic [1:0]    w_startOp;
   logic [CW-1:0] w_startLoad;

   logic signed [63:0] w_prodSigned;
   logic [63:0]        w_prodUnsigned;
   logic               w_divisorZero;
   logic [31:0]        w_safeDivisor;
   logic [31:0]        w_absA;
   logic [31:0]        w_absB;
   logic [31:0]        w_quotMag;
   logic [31:0]        w_remMag;
   logic [31:0]        w_quotSigned;
   logic [31:0]        w_remSigned;
   logic [31:0]        w_quotUnsigned;
   logic [31:0]        w_remUnsigned;
   logic [31:0]        w_commitHi;
   logic [31:0]        w_commitLo;
   logic               w_commitWrite;

   assign w_opcode       = E_instruction[31:26];
   assign w_funct        = E_instruction[5:0];
   assign w_isSpecial    = (w_opcode == 6'b000000);
   assign w_unusedFields = ^E_instruction[25:6];

   assign w_isMult  = w_isSpecial && (w_funct == FN_MULT);
   assign w_isMultu = w_isSpecial && (w_funct == FN_MULTU);
   assign w_isDiv   = w_isSpecial && (w_funct == FN_DIV);
   assign w_isDivu  = w_isSpecial && (w_funct == FN_DIVU);
   assign w_isMfhi  = w_isSpecial && (w_funct == FN_MFHI);
   assign w_isMflo  = w_isSpecial && (w_funct == FN_MFLO);
   assign w_isMthi  = w_isSpecial && (w_funct == FN_MTHI);
   assign w_isMtlo  = w_isSpecial && (w_funct == FN_MTLO);

   assign w_start     = w_isMult | w_isMultu | w_isDiv | w_isDivu;
   assign w_busy      = (r_cnt != '0);
   assign w_commit    = (r_cnt == CW'(1));
   assign w_startLoad = (w_isDiv | w_isDivu) ? DIV_LOAD : MULT_LOAD;

   always_comb begin
      w_startOp = OP_MULT;
      if (w_isMultu) begin
         w_startOp = OP_MULTU;
      end else if (w_isDiv) begin
         w_startOp = OP_DIV;
      end else if (w_isDivu) begin
         w_startOp = OP_DIVU;
      end
   end

   assign w_prodSigned   = $signed({{32{r_opA[31]}}, r_opA}) * $signed({{32{r_opB[31]}}, r_opB});
   assign w_prodUnsigned = {32'h0, r_opA} * {32'h0, r_opB};

   // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
   assign w_divisorZero  = (r_opB == 32'h0);
   assign w_safeDivisor  = w_divisorZero ? 32'd1 : r_opB;
   assign w_absA         = r_opA[31] ? (32'h0 - r_opA) : r_opA;
   assign w_absB         = w_safeDivisor[31] ? (32'h0 - w_safeDivisor) : w_safeDivisor;
   assign w_quotMag      = w_absA / w_absB;
   assign w_remMag       = w_absA % w_absB;
   assign w_quotSigned   = (r_opA[31] ^ r_opB[31]) ? (32'h0 - w_quotMag) : w_quotMag;
   assign w_remSigned    = r_opA[31] ? (32'h0 - w_remMag) : w_remMag;
   assign w_quotUnsigned = r_opA / w_safeDivisor;
   assign w_remUnsigned  = r_opA % w_safeDivisor;

   always_comb begin
      w_commitHi    = r_hi;
      w_commitLo    = r_lo;
      w_commitWrite = 1'b0;
      case (r_op)
         OP_MULT: begin
            {w_commitHi, w_commitLo} = w_prodSigned;
            w_commitWrite            = 1'b1;
         end
         OP_MULTU: begin
            {w_commitHi, w_commitLo} = w_prodUnsigned;
            w_commitWrite            = 1'b1;
         end
         OP_DIV: begin
            w_commitHi    = w_remSigned;
            w_commitLo    = w_quotSigned;
            w_commitWrite = !w_divisorZero;
         end
         OP_DIVU: begin
            w_commitHi    = w_remUnsigned;
            w_commitLo    = w_quotUnsigned;
            w_commitWrite = !w_divisorZero;
         end
         default: begin
            w_commitWrite = 1'b0;
         end
      endcase
   end

   // A start only loads when idle; while busy the counter just drains toward commit.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
         r_op  <= OP_MULT;
         r_opA <= 32'h0;
         r_opB <= 32'h0;
      end else if (w_busy) begin
         r_cnt <= r_cnt - CW'(1);
      end else if (w_start) begin
         r_cnt <= w_startLoad;
         r_op  <= w_startOp;
         r_opA <= E_rs_data;
         r_opB <= E_rt_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_hi <= 32'h0;
         r_lo <= 32'h0;
      end else if (w_commit) begin
         if (w_commitWrite) begin
            r_hi <= w_commitHi;
            r_lo <= w_commitLo;
         end
      end else if (!w_busy) begin
         if (w_isMthi) begin
            r_hi <= E_rs_data;
         end
         if (w_isMtlo) begin
            r_lo <= E_rs_data;
         end
      end
   end

   assign E_mdu_start = w_start;
   assign E_mdu_busy  = w_busy;
   assign E_mdu_stall = D_is_md & (w_start | w_busy);
   assign E_is_mf     = w_isMfhi | w_isMflo;
   assign E_mdu_out   = w_isMfhi ? r_hi : (w_isMflo ? r_lo : 32'h0);
   assign HI          = r_hi;
   assign LO          = r_lo;

endmodule
